// File: rtl/hsid_pkg.sv
// Shared widths and sequencer state encoding for the HSpecID-X run sequencer.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_BANDS_WIDTH   = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH = 16;

    typedef logic [3:0] hsid_seq_state_t;

    localparam hsid_seq_state_t HSID_S_IDLE     = 4'd0;
    localparam hsid_seq_state_t HSID_S_REQ_CAP  = 4'd1;
    localparam hsid_seq_state_t HSID_S_WAIT_CAP = 4'd2;
    localparam hsid_seq_state_t HSID_S_REQ_LIB  = 4'd3;
    localparam hsid_seq_state_t HSID_S_WAIT_LIB = 4'd4;
    localparam hsid_seq_state_t HSID_S_EMIT     = 4'd5;
    localparam hsid_seq_state_t HSID_S_DRAIN    = 4'd6;
    localparam hsid_seq_state_t HSID_S_DONE     = 4'd7;
    localparam hsid_seq_state_t HSID_S_ERROR    = 4'd8;
    localparam hsid_seq_state_t HSID_S_ABORT    = 4'd9;

endpackage

// File: rtl/hsid_x_mse_track.sv
// Running min/max of per-pixel MSE results; ties keep the earlier pixel ref.
module hsid_x_mse_track
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         valid,
    input  logic [WORD_WIDTH-1:0]        value,
    input  logic [HSP_LIBRARY_WIDTH-1:0] pix_ref,
    output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
    output logic [WORD_WIDTH-1:0]        min_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] max_ref,
    output logic [WORD_WIDTH-1:0]        max_value
);

    logic have_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_first <= 1'b0;
            min_ref    <= '0;
            min_value  <= '0;
            max_ref    <= '0;
            max_value  <= '0;
        end else if (clear) begin
            have_first <= 1'b0;
            min_ref    <= '0;
            min_value  <= '0;
            max_ref    <= '0;
            max_value  <= '0;
        end else if (valid) begin
            if (!have_first) begin
                have_first <= 1'b1;
                min_ref    <= pix_ref;
                min_value  <= value;
                max_ref    <= pix_ref;
                max_value  <= value;
            end else begin
                if (value < min_value) begin
                    min_ref   <= pix_ref;
                    min_value <= value;
                end
                if (value > max_value) begin
                    max_ref   <= pix_ref;
                    max_value <= value;
                end
            end
        end
    end

endmodule

// File: rtl/hsid_x_seq.sv
// HSpecID-X run sequencer: fetches captured/library band pairs over a read-only
// bus, streams them to the MSE datapath and tracks min/max MSE per run.
module hsid_x_seq
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         clear,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    input  logic [HSP_BANDS_WIDTH-1:0]   pixel_bands,
    input  logic [WORD_WIDTH-1:0]        captured_pixel_addr,
    input  logic [WORD_WIDTH-1:0]        library_pixel_addr,
    output logic                         idle,
    output logic                         ready,
    output logic                         done,
    output logic                         error,
    output logic                         mem_req,
    output logic [WORD_WIDTH-1:0]        mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [WORD_WIDTH-1:0]        mem_rdata,
    output logic                         band_valid,
    input  logic                         band_ready,
    output logic [WORD_WIDTH-1:0]        band_cap,
    output logic [WORD_WIDTH-1:0]        band_lib,
    output logic                         band_last,
    output logic [HSP_LIBRARY_WIDTH-1:0] band_ref,
    input  logic                         mse_valid,
    input  logic [WORD_WIDTH-1:0]        mse_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
    output logic [WORD_WIDTH-1:0]        mse_min_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
    output logic [WORD_WIDTH-1:0]        mse_max_value
);

    localparam int WW  = WORD_WIDTH;
    localparam int HBW = HSP_BANDS_WIDTH;
    localparam int HLW = HSP_LIBRARY_WIDTH;

    hsid_seq_state_t state, state_nxt;

    logic [HBW-1:0] bands_q, band_idx, band_nxt;
    logic [HLW-1:0] lib_size_q, pix_idx;
    logic [HLW:0]   res_cnt;
    logic [WW-1:0]  cap_base_q, lib_base_q, lib_off, addr_q;
    logic           abort_gnt;

    logic in_rest, in_req, in_wait, start_ok, cfg_bad, go, hs;
    logic last_band, last_pix, mse_acc, trk_clear;

    assign in_rest   = (state == HSID_S_IDLE) || (state == HSID_S_DONE) || (state == HSID_S_ERROR);
    assign in_req    = (state == HSID_S_REQ_CAP) || (state == HSID_S_REQ_LIB);
    assign in_wait   = (state == HSID_S_WAIT_CAP) || (state == HSID_S_WAIT_LIB);
    assign start_ok  = start && !clear && in_rest;
    assign cfg_bad   = (library_size == '0) || (pixel_bands == '0);
    assign go        = start_ok && !cfg_bad;
    assign hs        = (state == HSID_S_EMIT) && band_ready;
    assign last_band = (band_idx == bands_q - 1'b1);
    assign last_pix  = (pix_idx == lib_size_q - 1'b1);
    assign band_nxt  = last_band ? '0 : band_idx + 1'b1;
    assign mse_acc   = mse_valid && !in_rest;
    assign trk_clear = go || (state_nxt == HSID_S_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            HSID_S_IDLE, HSID_S_DONE, HSID_S_ERROR:
                if (start_ok) state_nxt = cfg_bad ? HSID_S_ERROR : HSID_S_REQ_CAP;
            HSID_S_REQ_CAP:  if (mem_gnt)    state_nxt = HSID_S_WAIT_CAP;
            HSID_S_WAIT_CAP: if (mem_rvalid) state_nxt = HSID_S_REQ_LIB;
            HSID_S_REQ_LIB:  if (mem_gnt)    state_nxt = HSID_S_WAIT_LIB;
            HSID_S_WAIT_LIB: if (mem_rvalid) state_nxt = HSID_S_EMIT;
            HSID_S_EMIT:     if (hs) state_nxt = (last_band && last_pix) ? HSID_S_DRAIN : HSID_S_REQ_CAP;
            HSID_S_DRAIN:    if (res_cnt == {1'b0, lib_size_q}) state_nxt = HSID_S_DONE;
            HSID_S_ABORT:    if (abort_gnt && mem_rvalid) state_nxt = HSID_S_IDLE;
            default:         state_nxt = HSID_S_IDLE;
        endcase
        // A read already in flight must be granted and its data drained before IDLE.
        if (clear && state != HSID_S_ABORT) begin
            if (in_req || (in_wait && !mem_rvalid)) state_nxt = HSID_S_ABORT;
            else                                    state_nxt = HSID_S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HSID_S_IDLE;
            bands_q    <= '0;
            lib_size_q <= '0;
            cap_base_q <= '0;
            lib_base_q <= '0;
            band_idx   <= '0;
            pix_idx    <= '0;
            res_cnt    <= '0;
            lib_off    <= '0;
            addr_q     <= '0;
            band_cap   <= '0;
            band_lib   <= '0;
        end else begin
            state <= state_nxt;
            if (go) begin
                bands_q    <= pixel_bands;
                lib_size_q <= library_size;
                cap_base_q <= captured_pixel_addr;
                lib_base_q <= library_pixel_addr;
                band_idx   <= '0;
                pix_idx    <= '0;
                res_cnt    <= '0;
                lib_off    <= '0;
                addr_q     <= captured_pixel_addr;
            end else begin
                if (mse_acc) res_cnt <= res_cnt + 1'b1;
                if (state == HSID_S_WAIT_CAP && mem_rvalid) begin
                    band_cap <= mem_rdata;
                    addr_q   <= lib_base_q + lib_off;
                    lib_off  <= lib_off + WW'(4);
                end
                if (state == HSID_S_WAIT_LIB && mem_rvalid) band_lib <= mem_rdata;
                if (hs) begin
                    band_idx <= band_nxt;
                    if (last_band) pix_idx <= pix_idx + 1'b1;
                    addr_q <= cap_base_q + {{(WW-HBW-2){1'b0}}, band_nxt, 2'b00};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_gnt <= 1'b0;
        end else if (clear && state != HSID_S_ABORT && (in_req || in_wait)) begin
            abort_gnt <= in_wait || mem_gnt;
        end else if (state == HSID_S_ABORT && mem_gnt) begin
            abort_gnt <= 1'b1;
        end
    end

    assign mem_req    = in_req || (state == HSID_S_ABORT && !abort_gnt);
    assign mem_addr   = addr_q;
    assign idle       = in_rest;
    assign ready      = (state == HSID_S_IDLE);
    assign done       = (state == HSID_S_DONE);
    assign error      = (state == HSID_S_ERROR);
    assign band_valid = (state == HSID_S_EMIT);
    assign band_last  = band_valid && last_band;
    assign band_ref   = pix_idx;

    hsid_x_mse_track #(
        .WORD_WIDTH        (WW),
        .HSP_LIBRARY_WIDTH (HLW)
    ) u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (trk_clear),
        .valid     (mse_acc),
        .value     (mse_value),
        .pix_ref   (res_cnt[HLW-1:0]),
        .min_ref   (mse_min_ref),
        .min_value (mse_min_value),
        .max_ref   (mse_max_ref),
        .max_value (mse_max_value)
    );

endmodule

// File: tb/tb_hsid_x_seq.sv
// Directed bench for hsid_x_seq with a behavioural bus/datapath responder.
module tb_hsid_x_seq;
    import hsid_pkg::*;

    localparam int WW  = HSID_WORD_WIDTH;
    localparam int HBW = HSID_HSP_BANDS_WIDTH;
    localparam int HLW = HSID_HSP_LIBRARY_WIDTH;

    logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0;
    logic [HLW-1:0] library_size = '0;
    logic [HBW-1:0] pixel_bands = '0;
    logic [WW-1:0]  captured_pixel_addr = '0, library_pixel_addr = '0;
    logic           idle, ready, done, error, mem_req, band_valid, band_last;
    logic [WW-1:0]  mem_addr, band_cap, band_lib, mse_min_value, mse_max_value;
    logic [HLW-1:0] band_ref, mse_min_ref, mse_max_ref;
    logic           mem_gnt = 1'b0, mem_rvalid = 1'b0, band_ready = 1'b1, mse_valid = 1'b0;
    logic [WW-1:0]  mem_rdata = '0, mse_value = '0;

    int n_cmp = 0, n_err = 0;
    int cfg_bands = 1, f_idx = 0, pair_k = 0, lib_gnts = 0, rv_cnt = 0;
    int stall_en = 0, lat_fix = 0, rdy_stall_req = 0, rdy_stalled = 0, rdy_cnt = 0;
    logic [WW-1:0] cfg_cap = '0, cfg_lib = '0;
    logic [WW-1:0] mse_tab [4];

    always #5 clk = ~clk;

    hsid_x_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .library_size(library_size), .pixel_bands(pixel_bands),
        .captured_pixel_addr(captured_pixel_addr), .library_pixel_addr(library_pixel_addr),
        .idle(idle), .ready(ready), .done(done), .error(error),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .band_valid(band_valid), .band_ready(band_ready), .band_cap(band_cap),
        .band_lib(band_lib), .band_last(band_last), .band_ref(band_ref),
        .mse_valid(mse_valid), .mse_value(mse_value),
        .mse_min_ref(mse_min_ref), .mse_min_value(mse_min_value),
        .mse_max_ref(mse_max_ref), .mse_max_value(mse_max_value)
    );

    function automatic logic [WW-1:0] memf(input logic [WW-1:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Fetch f: even = captured band k%bands, odd = library word k, with k = f/2.
    function automatic logic [WW-1:0] exp_fetch(input int f);
        int k;
        k = f / 2;
        if (f % 2 == 0) return cfg_cap + 32'(4 * (k % cfg_bands));
        return cfg_lib + 32'(4 * k);
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] req_v);
        n_cmp++;
        assert (obs === req_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_start(input int bands, input int lsz, input logic [WW-1:0] cap,
                             input logic [WW-1:0] lb, input logic [WW-1:0] v0,
                             input logic [WW-1:0] v1, input logic [WW-1:0] v2);
        @(negedge clk);
        cfg_bands = bands; cfg_cap = cap; cfg_lib = lb;
        mse_tab[0] = v0; mse_tab[1] = v1; mse_tab[2] = v2; mse_tab[3] = '0;
        f_idx = 0; pair_k = 0; rdy_stalled = 0;
        pixel_bands = HBW'(bands); library_size = HLW'(lsz);
        captured_pixel_addr = cap; library_pixel_addr = lb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        chk(tag, done, 1);
    endtask

    task automatic chk_res(input string tag, input int mnr, input int mnv, input int mxr, input int mxv);
        chk({tag, "_min_ref"}, mse_min_ref, mnr);
        chk({tag, "_min_val"}, mse_min_value, mnv);
        chk({tag, "_max_ref"}, mse_max_ref, mxr);
        chk({tag, "_max_val"}, mse_max_value, mxv);
    endtask

    initial begin
        logic         pend;
        int           pwait, b, p, rv_at, gbase;
        logic [WW-1:0] paddr, gaddr;
        logic         mse_pend;
        logic [WW-1:0] mse_pv;
        pend = 1'b0; pwait = 0; paddr = '0; gaddr = '0; mse_pend = 1'b0; mse_pv = '0;

        // Bus slave plus MSE datapath stand-in; checks every fetch and every offered pair.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    mem_rvalid = 1'b0;
                    if (mem_gnt) begin
                        mem_gnt = 1'b0; pend = 1'b1; paddr = gaddr;
                        pwait = (lat_fix > 0) ? lat_fix : (stall_en != 0 ? int'($urandom_range(0, 2)) : 0);
                    end
                    if (pend) begin
                        if (pwait == 0) begin
                            mem_rvalid = 1'b1; mem_rdata = memf(paddr); pend = 1'b0; rv_cnt++;
                        end else pwait--;
                    end else if (mem_req) begin
                        chk("mem_addr", mem_addr, exp_fetch(f_idx));
                        if (stall_en == 0 || $urandom_range(0, 1) == 1) begin
                            mem_gnt = 1'b1; gaddr = mem_addr;
                            if (f_idx % 2 == 1) lib_gnts++;
                            f_idx++;
                        end
                    end
                    mse_valid = 1'b0;
                    if (mse_pend) begin
                        mse_valid = 1'b1; mse_value = mse_pv; mse_pend = 1'b0;
                    end
                    if (band_valid && rdy_stall_req != 0 && rdy_stalled == 0) begin
                        rdy_cnt = 5; rdy_stalled = 1;
                    end
                    band_ready = (rdy_cnt == 0);
                    if (rdy_cnt > 0) rdy_cnt--;
                    if (band_valid) begin
                        b = pair_k % cfg_bands;
                        p = pair_k / cfg_bands;
                        chk("band_cap", band_cap, memf(cfg_cap + 32'(4 * b)));
                        chk("band_lib", band_lib, memf(cfg_lib + 32'(4 * pair_k)));
                        chk("band_last", band_last, (b == cfg_bands - 1));
                        chk("band_ref", band_ref, p);
                        if (band_ready) begin
                            if (b == cfg_bands - 1) begin
                                mse_pend = 1'b1; mse_pv = mse_tab[p];
                            end
                            pair_k++;
                        end
                    end
                end
            end
        join_none

        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_idle", idle, 1);
        chk("rst_ready", ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_band_valid", band_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_band_ref", band_ref, 0);
        chk_res("rst", 0, 0, 0, 0);

        // Nominal run, zero-wait memory.
        run_start(4, 3, 32'h100, 32'h200, 50, 20, 80);
        chk("s2_busy_idle", idle, 0);
        chk("s2_busy_ready", ready, 0);
        wait_done("s2_done");
        chk("s2_pairs", pair_k, 12);
        chk("s2_fetches", f_idx, 24);
        chk_res("s2", 1, 20, 2, 80);
        cyc(3);
        chk("s2_done_sticky", done, 1);
        chk("s2_idle", idle, 1);

        // Zero-size configurations go straight to ERROR without touching the bus.
        run_start(4, 0, 32'h100, 32'h200, 0, 0, 0);
        chk("s3_error", error, 1);
        chk("s3_ready", ready, 0);
        cyc(3);
        chk("s3_no_req", f_idx, 0);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("s3_clear_ready", ready, 1);
        chk("s3_clear_error", error, 0);
        run_start(0, 3, 32'h100, 32'h200, 0, 0, 0);
        chk("s3_bands0_error", error, 1);

        // Stalled bus and datapath, plus a start pulse while busy that must be ignored.
        stall_en = 1; rdy_stall_req = 1;
        run_start(4, 3, 32'h100, 32'h200, 50, 20, 80);
        cyc(10);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done("s4_done");
        chk("s4_ready_stalled", rdy_stalled, 1);
        chk("s4_pairs", pair_k, 12);
        chk_res("s4", 1, 20, 2, 80);
        stall_en = 0; rdy_stall_req = 0;

        // Clear while a library read is outstanding.
        lat_fix = 6;
        gbase = lib_gnts;
        run_start(4, 3, 32'h100, 32'h200, 50, 20, 80);
        for (int i = 0; i < 200 && lib_gnts == gbase; i++) @(negedge clk);
        chk("s5_lib_granted", lib_gnts, gbase + 1);
        @(negedge clk);
        rv_at = rv_cnt;
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("s5_abort_ready", ready, 0);
        chk("s5_abort_req", mem_req, 0);
        for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
        chk("s5_ready", ready, 1);
        chk("s5_swallowed", rv_cnt, rv_at + 1);
        chk("s5_no_pairs", pair_k, 0);
        chk_res("s5", 0, 0, 0, 0);
        lat_fix = 0;
        run_start(4, 3, 32'h100, 32'h200, 50, 20, 80);
        wait_done("s5_rerun_done");
        chk_res("s5_rerun", 1, 20, 2, 80);

        // Single-band pixels: every pair is a last band.
        run_start(1, 2, 32'h40, 32'h80, 7, 9, 0);
        wait_done("s7_done");
        chk("s7_pairs", pair_k, 2);
        chk_res("s7", 0, 7, 1, 9);

        // Ties keep ref 0; restart from DONE; start+clear together favours clear.
        run_start(4, 3, 32'h100, 32'h200, 30, 30, 30);
        wait_done("s6_done");
        chk_res("s6", 0, 30, 0, 30);
        run_start(2, 3, 32'h300, 32'h400, 50, 20, 80);
        chk("s6_restart_done", done, 0);
        wait_done("s6_rerun_done");
        chk_res("s6_rerun", 1, 20, 2, 80);
        @(negedge clk); start = 1'b1; clear = 1'b1;
        @(negedge clk); start = 1'b0; clear = 1'b0;
        chk("s6_sc_ready", ready, 1);
        chk("s6_sc_done", done, 0);
        chk("s6_sc_req", mem_req, 0);
        chk_res("s6_sc", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
